intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Sequences two traffic-light heads, north-south (NS) and east-west (EW), at a single intersection. Each head is driven with the team's 2-bit light code. The block runs a fixed green → flash-green → yellow → all-red cycle per direction. Green dwell responds to vehicle-presence sensors and latched pedestrian requests. It sits above the per-head light drivers and is the only block allowed to give a direction right-of-way.

## Interface
Parameters:
- MIN_GREEN = 8: minimum green dwell, in cycles (≥1)
- MAX_GREEN = 32: green dwell after which a waiting cross demand forces a change (≥ MIN_GREEN)
- FLASH_CYC = 3: flash-green dwell, in cycles (≥1)
- YELLOW_CYC = 2: yellow dwell, in cycles (≥1)
- ALLRED_CYC = 1: all-red clearance, in cycles (≥1)
- CW = 6: timer width; must hold MAX_GREEN-1

Ports:
- clk  in  1  single clock, rising edge
- rstb  in  1  reset, asynchronous, active-high
- car_ns  in  1  vehicle present on NS approach (level)
- car_ew  in  1  vehicle present on EW approach (level)
- ped_req_ns  in  1  pedestrian request for the NS phase (pulse or level)
- ped_req_ew  in  1  pedestrian request for the EW phase
- ns_light  out  2  NS head: green=00, flash_green=01, yellow=11, red=10
- ew_light  out  2  EW head, same code
- walk_ns  out  1  walk indication, NS phase
- walk_ew  out  1  walk indication, EW phase
- pend_ns  out  1  latched NS pedestrian request, not yet served
- pend_ew  out  1  latched EW pedestrian request, not yet served

## Operation
- State cycle, in order: NS_GREEN → NS_FLASH → NS_YELLOW → AR_TO_EW → EW_GREEN → EW_FLASH → EW_YELLOW → AR_TO_NS → NS_GREEN.
- Active head outputs follow the state name: green, flash_green or yellow. The other head is red. Both heads are red in the AR_* states.
- Invariant: ns_light and ew_light are never both non-red, in any cycle.
- Each state entry loads a down-counter with (dwell−1); dwell is the parameter for that state. Non-green states exit on the cycle the counter reads 0.
- Green exit: counter reached 0, MIN_GREEN satisfied, and cross demand present, where cross demand = car_other | pend_other. On top of that, one of the following must hold:
  - own-direction car is absent (gap-out), or
  - the elapsed-green count has reached MAX_GREEN (max-out).
- With no cross demand, green rests indefinitely. The elapsed-green count saturates at MAX_GREEN.
- pend_x is set by ped_req_x and cleared on the edge that enters X_GREEN.
- If ped_req_x is high on that same entry edge, the clear wins (the request is served).
- A request arriving during X_GREEN for the same phase is latched and serves the next cycle.
- walk_x = 1 throughout X_GREEN; 0 otherwise.
- All outputs are registered.

## Timing
- Reset values (asynchronous, held while rstb=1):
  - state NS_GREEN, ns_light=00, ew_light=10
  - walk_ns=1, walk_ew=0, pend_ns=pend_ew=0
  - timer loaded with MIN_GREEN-1, elapsed-green count 0
- The first state change can occur no earlier than MIN_GREEN cycles after reset release.
- Non-green state X occupies exactly its dwell parameter in cycles.
- Green with cross demand and no own car lasts exactly MIN_GREEN cycles. A continuous own car stretches it to exactly MAX_GREEN cycles.
- Inputs are sampled at the rising edge. A ped_req pulse at edge k shows pend=1 after edge k, and can enable a green exit at edge k+1.
- If cross demand disappears before the green exit edge, green keeps resting.
- Reset mid-cycle (any state) returns to NS_GREEN immediately, with no yellow. Latched requests are lost.
- Minimum full cycle: 2·(MIN_GREEN+FLASH_CYC+YELLOW_CYC+ALLRED_CYC) cycles. With defaults this is 28.

## Structure
- Package traffic_pkg:
  - 2-bit light-code constants (GREEN=00, FLASH_GREEN=01, YELLOW=11, RED=10)
  - 3-bit state enumeration for the eight states
- Sub-module phase_timer: loadable CW-bit down-counter with load, load value and done (count==0) outputs.
- The top level holds the FSM, the elapsed-green counter, the pend latches and the output registers.

## Test plan
- Reset, then car_ew=1, no car_ns: NS green for 8 cycles, flash 3, yellow 2, all-red 1, then EW green at cycle 14.
- No demand at all for 100 cycles: ns_light stays 00, ew_light stays 10, walk_ns=1 throughout.
- car_ns=1 and car_ew=1 held: NS green lasts exactly 32 cycles (max-out), then EW green also lasts 32.
- One-cycle ped_req_ew pulse at cycle 20 of NS rest: pend_ew=1 from cycle 21; NS leaves green at the next edge; pend_ew clears and walk_ew=1 on EW_GREEN entry.
- ped_req_ns held high on the NS_GREEN entry edge only: pend_ns stays 0 afterwards.
- rstb asserted during EW_YELLOW: outputs go to ns=00, ew=10 before the next clock edge. The assertion that the two heads are never both non-red holds for the whole run.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, intersection state encoding and per-head light decode
package traffic_pkg;
  localparam logic [1:0] GREEN = 2'b00, FLASH_GREEN = 2'b01, YELLOW = 2'b11, RED = 2'b10;
  typedef enum logic [2:0] {
    NS_GREEN, NS_FLASH, NS_YELLOW, AR_TO_EW, EW_GREEN, EW_FLASH, EW_YELLOW, AR_TO_NS
  } state_e;
  function automatic logic [1:0] head_light(state_e s, state_e g);
    return s == g ? GREEN : s == state_e'(g + 3'd1) ? FLASH_GREEN : s == state_e'(g + 3'd2) ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer: CW-bit down-counter (clk, rst, load, load_val in; done=count==0 out), holds at 0
module phase_timer #(
  parameter int CW = 6,
  parameter logic [CW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    done    = count_q == '0;
    count_d = load ? load_val : done ? count_q : count_q - 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= INIT;
    else count_q <= count_d;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: NS/EW light sequencer (car/ped inputs; registered lights, walk and pending-request outputs)
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MAX_GREEN  = 32,
  parameter int FLASH_CYC  = 3,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int CW         = 6
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       pend_ns,
  output logic       pend_ew
);
  localparam logic [CW-1:0] MIN_LD = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LD = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] FLS_LD = CW'(FLASH_CYC - 1);
  localparam logic [CW-1:0] YEL_LD = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] AR_LD  = CW'(ALLRED_CYC - 1);
  state_e state_q, state_d;
  logic [CW-1:0] elapsed_q, elapsed_d, ld_val;
  logic pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic [1:0] ns_light_q, ew_light_q;
  logic walk_ns_q, walk_ew_q;
  logic done, max_hit, leave;
  phase_timer #(.CW(CW), .INIT(MIN_LD)) u_timer (
    .clk(clk), .rst(rstb), .load(leave), .load_val(ld_val), .done(done)
  );
  // elapsed_q counts completed green cycles, so MAX_LD means this is the MAX_GREEN-th cycle
  always_comb begin
    max_hit   = elapsed_q == MAX_LD;
    leave     = state_q == NS_GREEN ? done && (car_ew || pend_ew_q) && (!car_ns || max_hit) :
                state_q == EW_GREEN ? done && (car_ns || pend_ns_q) && (!car_ew || max_hit) : done;
    state_d   = leave ? state_e'(state_q + 3'd1) : state_q;
    ld_val    = (state_d == NS_GREEN  || state_d == EW_GREEN)  ? MIN_LD :
                (state_d == NS_FLASH  || state_d == EW_FLASH)  ? FLS_LD :
                (state_d == NS_YELLOW || state_d == EW_YELLOW) ? YEL_LD : AR_LD;
    elapsed_d = leave ? '0 : max_hit ? elapsed_q : elapsed_q + 1'b1;
    pend_ns_d = (state_d == NS_GREEN && state_q != NS_GREEN) ? 1'b0 : pend_ns_q | ped_req_ns;
    pend_ew_d = (state_d == EW_GREEN && state_q != EW_GREEN) ? 1'b0 : pend_ew_q | ped_req_ew;
  end
  always_ff @(posedge clk or posedge rstb)
    if (rstb) state_q <= NS_GREEN;
    else state_q <= state_d;
  // outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      elapsed_q  <= '0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      ns_light_q <= GREEN;
      ew_light_q <= RED;
      walk_ns_q  <= 1'b1;
      walk_ew_q  <= 1'b0;
    end else begin
      elapsed_q  <= elapsed_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      ns_light_q <= head_light(state_d, NS_GREEN);
      ew_light_q <= head_light(state_d, EW_GREEN);
      walk_ns_q  <= state_d == NS_GREEN;
      walk_ew_q  <= state_d == EW_GREEN;
    end
  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk_ns  = walk_ns_q;
  assign walk_ew  = walk_ew_q;
  assign pend_ns  = pend_ns_q;
  assign pend_ew  = pend_ew_q;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: scoreboard bench for intersection_scheduler with default parameters
module tb_intersection_scheduler;
  localparam logic [1:0] G = 2'b00, F = 2'b01, Y = 2'b11, R = 2'b10;
  logic clk = 1'b0, rstb = 1'b0;
  logic car_ns = 1'b0, car_ew = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic walk_ns, walk_ew, pend_ns, pend_ew;
  int total = 0, bad = 0;
  logic [7:0] sb[$];
  intersection_scheduler dut (
    .clk(clk), .rstb(rstb), .car_ns(car_ns), .car_ew(car_ew),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_light(ns_light), .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .pend_ns(pend_ns), .pend_ew(pend_ew)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] w(input logic [1:0] ns, input logic [1:0] ew, input logic pn, input logic pe);
    return {ns, ew, ns == G, ew == G, pn, pe};
  endfunction
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, {ns_light, ew_light, walk_ns, walk_ew, pend_ns, pend_ew}, sb.pop_front());
  endtask
  task automatic run(input string tag, input int n, input logic [7:0] e);
    repeat (n) step(tag, e);
  endtask
  task automatic do_reset();
    rstb = 1'b1;
    #2;
    chk("rst", {ns_light, ew_light, walk_ns, walk_ew, pend_ns, pend_ew}, w(G, R, 0, 0));
    @(posedge clk);
    #1;
    rstb = 1'b0;
  endtask
  always @(negedge clk) chk("excl", {7'd0, ns_light != R && ew_light != R}, 8'd0);
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
  initial begin
    car_ew = 1'b1;
    do_reset();
    run("t1_nsg", 7, w(G, R, 0, 0));
    run("t1_nsf", 3, w(F, R, 0, 0));
    run("t1_nsy", 2, w(Y, R, 0, 0));
    run("t1_ar", 1, w(R, R, 0, 0));
    car_ew = 1'b0;
    car_ns = 1'b1;
    run("t1_ewg", 8, w(R, G, 0, 0));
    run("t1_ewf", 3, w(R, F, 0, 0));
    run("t1_ewy", 1, w(R, Y, 0, 0));
    car_ns = 1'b0;
    do_reset();
    run("t2_rest", 100, w(G, R, 0, 0));
    car_ns = 1'b1;
    car_ew = 1'b1;
    do_reset();
    run("t3_nsg", 31, w(G, R, 0, 0));
    run("t3_nsf", 3, w(F, R, 0, 0));
    run("t3_nsy", 2, w(Y, R, 0, 0));
    run("t3_ar", 1, w(R, R, 0, 0));
    run("t3_ewg", 32, w(R, G, 0, 0));
    run("t3_ewf", 3, w(R, F, 0, 0));
    run("t3_ewy", 2, w(R, Y, 0, 0));
    run("t3_ar2", 1, w(R, R, 0, 0));
    run("t3_nsg2", 2, w(G, R, 0, 0));
    car_ns = 1'b0;
    car_ew = 1'b0;
    do_reset();
    run("t4_rest", 19, w(G, R, 0, 0));
    ped_req_ew = 1'b1;
    step("t4_pend", w(G, R, 0, 1));
    ped_req_ew = 1'b0;
    run("t4_nsf", 3, w(F, R, 0, 1));
    run("t4_nsy", 2, w(Y, R, 0, 1));
    run("t4_ar", 1, w(R, R, 0, 1));
    run("t4_ewg", 10, w(R, G, 0, 0));
    car_ns = 1'b1;
    run("t5_ewf", 3, w(R, F, 0, 0));
    run("t5_ewy", 2, w(R, Y, 0, 0));
    run("t5_ar", 1, w(R, R, 0, 0));
    ped_req_ns = 1'b1;
    step("t5_entry", w(G, R, 0, 0));
    ped_req_ns = 1'b0;
    run("t5_nsg", 5, w(G, R, 0, 0));
    ped_req_ew = 1'b1;
    step("t5_pend", w(G, R, 0, 1));
    ped_req_ew = 1'b0;
    car_ns = 1'b0;
    do_reset();
    run("t6_post", 3, w(G, R, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
